// File: rtl/vga_text_renderer_pkg.sv
// Shared types and constants for the text-mode renderer: char-map attribute
// layout, default geometry and the 16-colour CGA palette.
package vgachargen_pkg;

    localparam int DEF_CHAR_W = 8;
    localparam int DEF_CHAR_H = 16;
    localparam int DEF_COLS   = 80;
    localparam int DEF_ROWS   = 30;

    // Packed so that the low 17 bits of a char-map word cast straight onto it.
    typedef struct packed {
        logic       blink;
        logic [3:0] bg;
        logic [3:0] fg;
        logic [7:0] code;
    } char_attr_t;

    localparam logic [11:0] PALETTE [0:15] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

endpackage

// File: rtl/vga_text_renderer_if.sv
// Read-side bus to the char-map BRAM (port B) and the font ROM; both answer
// one cycle after the address is presented.
interface vga_text_renderer_if #(
    parameter int CH_ADDR_WIDTH   = 12,
    parameter int CH_DATA_WIDTH   = 32,
    parameter int FONT_ADDR_WIDTH = 12,
    parameter int CHAR_W          = 8
);
    logic [CH_ADDR_WIDTH-1:0]   ch_addr;
    logic [CH_DATA_WIDTH-1:0]   ch_data;
    logic [FONT_ADDR_WIDTH-1:0] font_addr;
    logic [CHAR_W-1:0]          font_data;

    modport master (output ch_addr, output font_addr, input ch_data, input font_data);
    modport slave  (input ch_addr, input font_addr, output ch_data, output font_data);
endinterface

// File: rtl/vga_text_renderer_blink_ctrl.sv
// Frame counter clocked by vsync falling edges; flips blink_phase every
// BLINK_FRAMES frames. Phase can only move at vsync, never mid-frame.
module vga_blink_ctrl #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vsync_i,
    output logic blink_phase_o
);
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          vs_prev_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (vs_prev_q && !vsync_i) begin
            if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
                cnt_d   = '0;
                phase_d = !phase_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Previous vsync resets high so leaving reset never looks like an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            vs_prev_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            vs_prev_q <= vsync_i;
        end
    end

    assign blink_phase_o = phase_q;
endmodule

// File: rtl/vga_text_renderer.sv
// Three-stage text renderer: pixel -> char-map address -> font row -> RGB,
// with syncs delayed to stay aligned with the colour output.
module vga_text_renderer
    import vgachargen_pkg::*;
#(
    parameter int CHAR_W        = DEF_CHAR_W,
    parameter int CHAR_H        = DEF_CHAR_H,
    parameter int COLS          = DEF_COLS,
    parameter int ROWS          = DEF_ROWS,
    parameter int CH_ADDR_WIDTH = 12,
    parameter int CH_DATA_WIDTH = 32,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic        active_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    vga_text_renderer_if.master mem,
    output logic [11:0] rgb_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        active_o
);
    localparam int FONT_ADDR_WIDTH = 8 + $clog2(CHAR_H);
    localparam int GXW = $clog2(CHAR_W);
    localparam int GYW = $clog2(CHAR_H);

    logic [9:0]     col, row;
    logic           in_text;
    logic           in_text_s1_q, in_text_s2_q;
    logic [GYW-1:0] gy_s1_q;
    logic [GXW-1:0] gx_s1_q, gx_s2_q;
    char_attr_t     attr_d, attr_s2_q;
    logic           pix, show_fg, blink_phase;
    logic [11:0]    rgb_d, rgb_q;
    logic [2:0][2:0] sync_q;   // {hsync, vsync, active} per stage
    logic           unused_ch_bits;

    vga_blink_ctrl #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .vsync_i      (vsync_i),
        .blink_phase_o(blink_phase)
    );

    always_comb begin
        col     = x_i >> GXW;
        row     = y_i >> GYW;
        in_text = active_i && (32'(col) < 32'(COLS)) && (32'(row) < 32'(ROWS));
        mem.ch_addr = in_text ? CH_ADDR_WIDTH'(32'(row) * 32'(COLS) + 32'(col)) : '0;
    end

    always_comb begin
        attr_d        = char_attr_t'(mem.ch_data[16:0]);
        mem.font_addr = {attr_d.code, gy_s1_q};
    end

    // Leftmost pixel is the font row MSB; blink only suppresses foreground.
    always_comb begin
        pix     = mem.font_data[GXW'(CHAR_W - 1) - gx_s2_q];
        show_fg = pix && !(attr_s2_q.blink && blink_phase);
        rgb_d   = 12'h000;
        if (in_text_s2_q)
            rgb_d = PALETTE[show_fg ? attr_s2_q.fg : attr_s2_q.bg];
    end

    assign unused_ch_bits = ^mem.ch_data[CH_DATA_WIDTH-1:17];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_text_s1_q <= 1'b0;
            gy_s1_q      <= '0;
            gx_s1_q      <= '0;
            in_text_s2_q <= 1'b0;
            gx_s2_q      <= '0;
            attr_s2_q    <= '0;
            rgb_q        <= '0;
            sync_q       <= {3{3'b110}};
        end else begin
            in_text_s1_q <= in_text;
            gy_s1_q      <= y_i[GYW-1:0];
            gx_s1_q      <= x_i[GXW-1:0];
            in_text_s2_q <= in_text_s1_q;
            gx_s2_q      <= gx_s1_q;
            attr_s2_q    <= attr_d;
            rgb_q        <= rgb_d;
            sync_q       <= {sync_q[1:0], {hsync_i, vsync_i, active_i}};
        end
    end

    assign rgb_o                        = rgb_q;
    assign {hsync_o, vsync_o, active_o} = sync_q[2];
endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: BRAM/ROM models, per-cycle history capture and
// a spec-level pixel model checked per scenario.
module tb_vga_text_renderer;
    localparam int BF = 2;

    logic clk, rst;
    logic [9:0] x, y;
    logic act, hs, vs;
    logic [11:0] rgb_o;
    logic hsync_o, vsync_o, active_o;

    vga_text_renderer_if #(.CH_ADDR_WIDTH(12), .CH_DATA_WIDTH(32),
                           .FONT_ADDR_WIDTH(12), .CHAR_W(8)) mem_if ();

    vga_text_renderer #(.CHAR_W(8), .CHAR_H(16), .COLS(80), .ROWS(30),
                        .CH_ADDR_WIDTH(12), .CH_DATA_WIDTH(32),
                        .BLINK_FRAMES(BF)) dut (
        .clk_i(clk), .rst_i(rst), .x_i(x), .y_i(y), .active_i(act),
        .hsync_i(hs), .vsync_i(vs), .mem(mem_if),
        .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .active_o(active_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem  [4096];
    logic [7:0]  font [4096];
    always @(posedge clk) begin
        mem_if.ch_data   <= mem[mem_if.ch_addr];
        mem_if.font_data <= font[mem_if.font_addr];
    end

    localparam logic [11:0] PAL [0:15] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

    // History: inputs and combinational addresses by input index k; registered
    // outputs sampled after clock edge k (so input k shows up at index k+2).
    logic [9:0]  hx [2048];
    logic [9:0]  hy [2048];
    logic        ha [2048];
    logic        hh [2048];
    logic        hv [2048];
    logic [11:0] h_addr [2048];
    logic [11:0] h_fa   [2048];
    logic [11:0] o_rgb  [2048];
    logic        o_hs [2048];
    logic        o_vs [2048];
    logic        o_act [2048];
    int cyc, n_chk, n_pass;

    task automatic step(input int xi, input int yi, input bit a, input bit h, input bit v);
        x = 10'(xi); y = 10'(yi); act = a; hs = h; vs = v;
        #1;
        hx[cyc] = x; hy[cyc] = y; ha[cyc] = a; hh[cyc] = h; hv[cyc] = v;
        h_addr[cyc] = mem_if.ch_addr;
        @(posedge clk);
        @(negedge clk);
        h_fa[cyc] = mem_if.font_addr;
        o_rgb[cyc] = rgb_o; o_hs[cyc] = hsync_o; o_vs[cyc] = vsync_o; o_act[cyc] = active_o;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; x = '0; y = '0; act = 1'b0; hs = 1'b1; vs = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    function automatic bit m_in_text(int k);
        return ha[k] && (int'(hx[k]) / 8 < 80) && (int'(hy[k]) / 16 < 30);
    endfunction

    function automatic int m_addr(int k);
        return m_in_text(k) ? (int'(hy[k]) / 16) * 80 + int'(hx[k]) / 8 : 0;
    endfunction

    // Blink phase after the vsync falling edges seen in inputs 0..k.
    function automatic bit m_phase(int k);
        int edges = 0;
        bit prev = 1'b1;
        for (int j = 0; j <= k; j++) begin
            if (prev && !hv[j]) edges++;
            prev = hv[j];
        end
        return ((edges / BF) % 2) == 1;
    endfunction

    function automatic logic [11:0] m_fa(int k);
        logic [31:0] w = mem[m_addr(k)];
        logic [9:0]  yy = hy[k];
        return {w[7:0], yy[3:0]};
    endfunction

    function automatic logic [11:0] m_rgb(int k);
        logic [31:0] w;
        logic [7:0]  fr;
        bit          b;
        if (!m_in_text(k)) return 12'h000;
        w  = mem[m_addr(k)];
        fr = font[m_fa(k)];
        b  = fr[7 - int'(hx[k]) % 8];
        return (b && !(w[16] && m_phase(k + 1))) ? PAL[w[11:8]] : PAL[w[15:12]];
    endfunction

    task automatic test_reset();
        rst = 1'b1; x = '0; y = '0; act = 1'b1; hs = 1'b0; vs = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (rgb_o !== 12'h000) $display("FAIL reset_rgb got %h want 000", rgb_o); else n_pass++;
        n_chk++; if (hsync_o !== 1'b1) $display("FAIL reset_hsync got %b want 1", hsync_o); else n_pass++;
        n_chk++; if (vsync_o !== 1'b1) $display("FAIL reset_vsync got %b want 1", vsync_o); else n_pass++;
        n_chk++; if (active_o !== 1'b0) $display("FAIL reset_active got %b want 0", active_o); else n_pass++;
        do_reset();
    endtask

    task automatic test_first_cell();
        do_reset();
        mem[0] = 32'h0000_0F41; font[12'h410] = 8'h80;
        step(0, 0, 1'b1, 1'b1, 1'b1);
        step(1, 0, 1'b1, 1'b1, 1'b1);
        idle(4);
        n_chk++; if (h_addr[0] !== 12'd0) $display("FAIL first_addr got %0d want 0", h_addr[0]); else n_pass++;
        n_chk++; if (h_fa[0] !== 12'h410) $display("FAIL first_font_addr got %h want 410", h_fa[0]); else n_pass++;
        for (int j = 0; j < 2; j++) begin
            n_chk++;
            if (o_rgb[j] !== 12'h000 || o_act[j] !== 1'b0 || o_hs[j] !== 1'b1)
                $display("FAIL first_blank[%0d] got rgb=%h act=%b hs=%b want 000/0/1", j, o_rgb[j], o_act[j], o_hs[j]);
            else n_pass++;
        end
        n_chk++; if (o_rgb[2] !== 12'hFFF) $display("FAIL first_rgb got %h want FFF", o_rgb[2]); else n_pass++;
        n_chk++; if (o_act[2] !== 1'b1) $display("FAIL first_active got %b want 1", o_act[2]); else n_pass++;
        n_chk++; if (o_rgb[3] !== 12'h000) $display("FAIL first_x1_rgb got %h want 000", o_rgb[3]); else n_pass++;
    endtask

    task automatic test_last_cell();
        do_reset();
        mem[2399] = 32'h0000_1E20; font[12'h20F] = 8'h01;
        step(639, 479, 1'b1, 1'b1, 1'b1);
        step(640, 479, 1'b1, 1'b1, 1'b1);
        step(0, 480, 1'b1, 1'b1, 1'b1);
        idle(3);
        n_chk++; if (h_addr[0] !== 12'd2399) $display("FAIL last_addr got %0d want 2399", h_addr[0]); else n_pass++;
        n_chk++; if (h_fa[0] !== 12'h20F) $display("FAIL last_font_addr got %h want 20F", h_fa[0]); else n_pass++;
        n_chk++; if (o_rgb[2] !== 12'hFF5) $display("FAIL last_rgb got %h want FF5", o_rgb[2]); else n_pass++;
        n_chk++; if (h_addr[1] !== 12'd0) $display("FAIL beyond_x_addr got %0d want 0", h_addr[1]); else n_pass++;
        n_chk++; if (o_rgb[3] !== 12'h000) $display("FAIL beyond_x_rgb got %h want 000", o_rgb[3]); else n_pass++;
        n_chk++; if (h_addr[2] !== 12'd0) $display("FAIL beyond_y_addr got %0d want 0", h_addr[2]); else n_pass++;
        n_chk++; if (o_rgb[4] !== 12'h000) $display("FAIL beyond_y_rgb got %h want 000", o_rgb[4]); else n_pass++;
    endtask

    task automatic test_random();
        int xi, yi;
        bit a;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = $urandom; font[i] = 8'($urandom);
        end
        do_reset();
        for (int i = 0; i < 600; i++) begin
            xi = $urandom_range(0, 799); yi = $urandom_range(0, 524);
            a = (xi < 640 && yi < 480) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
            step(xi, yi, a, 1'b1, 1'b1);
        end
        idle(3);
        for (int k = 0; k < cyc - 3; k++) begin
            n_chk++;
            if (h_addr[k] !== 12'(m_addr(k)))
                $display("FAIL rand_addr k=%0d got %0d want %0d", k, h_addr[k], m_addr(k));
            else n_pass++;
            n_chk++;
            if (h_fa[k] !== m_fa(k))
                $display("FAIL rand_font_addr k=%0d got %h want %h", k, h_fa[k], m_fa(k));
            else n_pass++;
            n_chk++;
            if (o_rgb[k + 2] !== m_rgb(k))
                $display("FAIL rand_rgb k=%0d got %h want %h", k, o_rgb[k + 2], m_rgb(k));
            else n_pass++;
        end
    endtask

    task automatic test_sync_toggle();
        int yi;
        do_reset();
        yi = $urandom_range(0, 479);
        for (int xi = 0; xi < 800; xi++)
            step(xi, yi, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(3);
        for (int k = 0; k < cyc - 3; k++) begin
            n_chk++;
            if (o_hs[k + 2] !== hh[k] || o_vs[k + 2] !== hv[k] || o_act[k + 2] !== ha[k])
                $display("FAIL sync_delay k=%0d got hs=%b vs=%b act=%b want %b/%b/%b",
                         k, o_hs[k + 2], o_vs[k + 2], o_act[k + 2], hh[k], hv[k], ha[k]);
            else n_pass++;
            n_chk++;
            if (o_rgb[k + 2] !== m_rgb(k))
                $display("FAIL sync_rgb k=%0d got %h want %h", k, o_rgb[k + 2], m_rgb(k));
            else n_pass++;
        end
    endtask

    task automatic test_blink();
        int idx;
        logic [11:0] want;
        do_reset();
        mem[0] = 32'h0001_1F41; font[12'h410] = 8'h80;
        for (int f = 0; f < 6; f++) begin
            step(0, 0, 1'b1, 1'b1, 1'b1);
            idx = cyc - 1;
            idle(3);
            want = (f < 2 || f >= 4) ? 12'hFFF : 12'h00A;
            n_chk++;
            if (o_rgb[idx + 2] !== want)
                $display("FAIL blink_frame%0d got %h want %h", f, o_rgb[idx + 2], want);
            else n_pass++;
            step(0, 0, 1'b0, 1'b1, 1'b0);
            step(0, 0, 1'b0, 1'b1, 1'b0);
            step(0, 0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem[0] = 32'h0001_1F41; font[12'h410] = 8'h80;
        for (int p = 0; p < 2; p++) begin
            step(0, 0, 1'b0, 1'b1, 1'b0);
            step(0, 0, 1'b0, 1'b1, 1'b1);
        end
        for (int xi = 290; xi < 300; xi++) step(xi, 0, 1'b1, 1'b0, 1'b0);
        x = 10'd300; y = '0; act = 1'b1; hs = 1'b0; vs = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_chk++; if (rgb_o !== 12'h000) $display("FAIL midrst_rgb got %h want 000", rgb_o); else n_pass++;
        n_chk++;
        if (hsync_o !== 1'b1 || vsync_o !== 1'b1 || active_o !== 1'b0)
            $display("FAIL midrst_sync got hs=%b vs=%b act=%b want 1/1/0", hsync_o, vsync_o, active_o);
        else n_pass++;
        x = '0; act = 1'b0; hs = 1'b1; vs = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        step(0, 0, 1'b1, 1'b1, 1'b1);
        idle(3);
        for (int j = 0; j < 2; j++) begin
            n_chk++;
            if (o_rgb[j] !== 12'h000 || o_act[j] !== 1'b0)
                $display("FAIL midrst_blank[%0d] got rgb=%h act=%b want 000/0", j, o_rgb[j], o_act[j]);
            else n_pass++;
        end
        n_chk++; if (o_rgb[2] !== 12'hFFF) $display("FAIL midrst_phase0_rgb got %h want FFF", o_rgb[2]); else n_pass++;
        n_chk++; if (o_act[2] !== 1'b1) $display("FAIL midrst_active got %b want 1", o_act[2]); else n_pass++;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0;
        rst = 1'b1; x = '0; y = '0; act = 1'b0; hs = 1'b1; vs = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = $urandom; font[i] = 8'($urandom);
        end
        test_reset();
        test_first_cell();
        test_last_cell();
        test_random();
        test_sync_toggle();
        test_blink();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_text_renderer.md
Name: vga_text_renderer

Overview:
- Downstream consumer of the character-map BRAM read port (port B, 1-cycle registered read).
- Turns pixel coordinates from the VGA timing generator into a character-map address, then a font-row address, then a 12-bit RGB pixel.
- Delays hsync/vsync/active so they stay aligned with the RGB output.
- Adds a frame-based blink attribute.

Parameters:
- CHAR_W, 8, glyph width in pixels; power of 2.
- CHAR_H, 16, glyph height in pixels; power of 2.
- COLS, 80, text columns.
- ROWS, 30, text rows.
- CH_ADDR_WIDTH, 12, char-map address width; must satisfy COLS*ROWS <= 2**CH_ADDR_WIDTH.
- CH_DATA_WIDTH, 32, char-map word width.
- BLINK_FRAMES, 30, frames per blink half-period; must be >= 1.
- FONT_ADDR_WIDTH (localparam), 8+$clog2(CHAR_H).

Ports:
- clk_i  in  1  pixel clock.
- rst_i  in  1  asynchronous, active-high reset.
- x_i  in  10  current pixel column from the timing generator.
- y_i  in  10  current pixel row.
- active_i  in  1  visible-area flag.
- hsync_i  in  1  horizontal sync, aligned with x_i.
- vsync_i  in  1  vertical sync, aligned with x_i.
- ch_addr_o  out  CH_ADDR_WIDTH  char-map read address; combinational.
- ch_data_i  in  CH_DATA_WIDTH  char-map word; valid 1 cycle after ch_addr_o.
- font_addr_o  out  FONT_ADDR_WIDTH  font ROM address; combinational.
- font_data_i  in  CHAR_W  font row; valid 1 cycle after font_addr_o.
- rgb_o  out  12  pixel colour, {R[3:0],G[3:0],B[3:0]}.
- hsync_o  out  1  delayed hsync.
- vsync_o  out  1  delayed vsync.
- active_o  out  1  delayed active.

Behaviour:
- Char-map word fields:
  - [7:0] character code.
  - [11:8] fg index.
  - [15:12] bg index.
  - [16] blink.
  - Other bits ignored.
- S0, cycle t:
  - col = x_i / CHAR_W; row = y_i / CHAR_H.
  - in_text = active_i && col < COLS && row < ROWS.
  - ch_addr_o = row*COLS + col when in_text, else 0.
  - Register in_text, y_i % CHAR_H, x_i % CHAR_W, and the sync signals.
- S1, cycle t+1:
  - font_addr_o = {ch_data_i[7:0], glyph_row} from the registered S0 values.
  - Register fg, bg, blink and the S0 pipeline values.
- S2, cycle t+2:
  - pixel bit = font_data_i[CHAR_W-1-glyph_col]; the MSB is the leftmost pixel.
  - Colour index:
    - bg if the bit is 0.
    - bg if the bit is 1 and blink && blink_phase.
    - fg otherwise.
  - rgb_o is registered from PALETTE[index], or 12'h000 when !in_text.
- Latency: fixed 3 cycles from x_i/y_i/sync to rgb_o, hsync_o, vsync_o and active_o. Throughput is one pixel per clock with no stalls.
- Blink logic:
  - Frame counter increments on each vsync_i falling edge (start of sync pulse, active-low).
  - At BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles.
  - The toggle applies from the next pixel; a frame mid-render may change phase only at vsync, i.e. never within a visible frame.
- Reset, asynchronous and immediate:
  - rgb_o = 0, active_o = 0, hsync_o = 1, vsync_o = 1 (inactive, active-low VGA).
  - All pipeline registers cleared; frame counter = 0; blink_phase = 0.
  - Reset mid-frame: outputs are blank until 3 cycles after the first post-reset pixel.
  - The vsync edge detector's previous-value register resets to 1, so no spurious edge follows reset.
- Boundaries:
  - x/y inside active but beyond the text area: black output, address 0.
  - Last cell (col 79, row 29): address 2399.
  - Code 0xFF, glyph row 15: font_addr 0xFFF.

Decomposition:
- Shared package vgachargen_pkg holds:
  - char_attr_t packed struct (code, fg, bg, blink).
  - The 16-entry 12-bit CGA PALETTE constant.
  - Default CHAR_W/CHAR_H/COLS/ROWS constants.
- One sub-module, vga_blink_ctrl: vsync edge detector, frame counter and blink_phase.

Test Plan:
- Reset, then x=0,y=0,active=1, mem[0]=0x0000_0F41 ('A', fg 15, bg 0), font row0=8'h80:
  - ch_addr_o=0 at t; font_addr_o=0x410 at t+1; rgb_o=12'hFFF at t+3.
  - x=1 on the next cycle gives rgb_o=12'h000.
- x=639,y=479, mem[2399]=0x0000_1E20, font=8'h01:
  - ch_addr_o=2399; font_addr_o=0x20F; rgb_o=PALETTE[14] for x=639.
- Toggle hsync_i/vsync_i/active_i with x=0..799:
  - Each output equals its input delayed exactly 3 cycles.
  - rgb_o=0 whenever active_o=0.
- Blink bit set, BLINK_FRAMES=2, glyph pixel 1:
  - fg shown in frames 0-1, bg in frames 2-3, fg in frames 4-5 (phase toggles on every 2nd vsync falling edge).
- Assert rst_i mid-line at x=300:
  - Outputs immediately rgb=0, hsync=vsync=1, active=0.
  - After release, the first valid pixel appears 3 cycles after inputs resume; blink_phase=0.
